// File: rtl/word_store_unit_if.sv
// Store-request and MMU port A bundle of word_store_unit.
// slave is the store unit itself; master is the execute stage / MMU side.
interface word_store_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  store_valid;
  logic                  store_ready;
  logic [ADDR_WIDTH-1:0] store_addr;
  logic [31:0]           store_data;
  logic [1:0]            store_size;
  logic                  store_done;
  logic                  store_misaligned;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [7:0]            mem_data;
  logic                  mem_we;
  logic                  mem_request;
  logic                  mem_busy;

  modport slave (
    input  store_valid, store_addr, store_data, store_size, mem_busy,
    output store_ready, store_done, store_misaligned,
           mem_addr, mem_data, mem_we, mem_request
  );

  modport master (
    output store_valid, store_addr, store_data, store_size, mem_busy,
    input  store_ready, store_done, store_misaligned,
           mem_addr, mem_data, mem_we, mem_request
  );
endinterface

// File: rtl/word_store_unit.sv
// Byte-serial big-endian sb/sh/sw store engine driving MMU port A, one byte per transaction.
// Define WORD_STORE_UNALIGNED_EN to accept half/word stores at any byte address.
module word_store_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input logic              clk,
  input logic              reset,
  word_store_unit_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE,
    ERR
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] AddrOne = ADDR_WIDTH'(1);

  state_t                state;
  state_t                nextState;
  logic [1:0]            byteIdx;
  logic [1:0]            lastIdx;
  logic [23:0]           pendingBytes;
  logic [ADDR_WIDTH-1:0] memAddr;
  logic [7:0]            memData;

  logic                  legal;
  logic [1:0]            reqLastIdx;
  logic [31:0]           reqAligned;
  logic                  storeReady;
  logic                  memRequest;
  logic                  storeDone;
  logic                  storeMisaligned;
  logic                  acceptStore;
  logic                  advanceByte;

  // Request decode: left-justify the stored bytes so byte 0 is always [31:24].
  // NOTE: every signal written in an always_comb gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    reqLastIdx = 2'd0;
    reqAligned = {bus.store_data[7:0], 24'd0};
    case (bus.store_size)
      2'd1: begin
        reqLastIdx = 2'd1;
        reqAligned = {bus.store_data[15:0], 16'd0};
      end
      2'd2: begin
        reqLastIdx = 2'd3;
        reqAligned = bus.store_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    legal = 1'b0;
`ifdef WORD_STORE_UNALIGNED_EN
    legal = (bus.store_size != 2'd3);
`else
    case (bus.store_size)
      2'd0:    legal = 1'b1;
      2'd1:    legal = ~bus.store_addr[0];
      2'd2:    legal = (bus.store_addr[1:0] == 2'b00);
      default: legal = 1'b0;
    endcase
`endif
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next state and state-decoded outputs; mem_busy only steers the next state.
  always_comb begin
    nextState       = state;
    storeReady      = 1'b0;
    memRequest      = 1'b0;
    storeDone       = 1'b0;
    storeMisaligned = 1'b0;
    acceptStore     = 1'b0;
    advanceByte     = 1'b0;
    case (state)
      IDLE: begin
        storeReady = 1'b1;
        if (bus.store_valid) begin
          acceptStore = legal;
          nextState   = legal ? ISSUE : ERR;
        end
      end
      ISSUE: begin
        memRequest = 1'b1;
        nextState  = WAIT;
      end
      WAIT: begin
        memRequest = 1'b1;
        if (!bus.mem_busy) begin
          if (byteIdx == lastIdx) begin
            nextState = DONE;
          end else begin
            advanceByte = 1'b1;
            nextState   = ISSUE;
          end
        end
      end
      DONE: begin
        storeDone = 1'b1;
        nextState = IDLE;
      end
      ERR: begin
        storeMisaligned = 1'b1;
        nextState       = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Byte datapath: address/data move only on the edge that enters ISSUE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      byteIdx      <= 2'd0;
      lastIdx      <= 2'd0;
      pendingBytes <= 24'd0;
      memAddr      <= '0;
      memData      <= 8'd0;
    end else if (acceptStore) begin
      byteIdx      <= 2'd0;
      lastIdx      <= reqLastIdx;
      memAddr      <= bus.store_addr;
      memData      <= reqAligned[31:24];
      pendingBytes <= reqAligned[23:0];
    end else if (advanceByte) begin
      byteIdx      <= byteIdx + 2'd1;
      memAddr      <= memAddr + AddrOne;
      memData      <= pendingBytes[23:16];
      pendingBytes <= {pendingBytes[15:0], 8'd0};
    end
  end

  assign bus.store_ready      = storeReady;
  assign bus.store_done       = storeDone;
  assign bus.store_misaligned = storeMisaligned;
  assign bus.mem_request      = memRequest;
  assign bus.mem_we           = memRequest;
  assign bus.mem_addr         = memAddr;
  assign bus.mem_data         = memData;

endmodule

// File: doc/word_store_unit.md
# word_store_unit

Byte-serial store engine for the MIPS dataflow core. It accepts one `sb`/`sh`/`sw` request at a time and writes it to the data port (port A) of the byte-wide MMU, one byte per memory transaction, in big-endian order. It is the write-side counterpart of the opcode buffer, which assembles bytes read from MMU port B. The execute stage drives it and stalls the pipeline while `store_ready` is low.

## Interface

Parameters:
- `ADDR_WIDTH`, default 32: width of the byte address.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  reset, synchronous and active-low.
- `store_valid`  in  1  store request. Sampled only while `store_ready`=1.
- `store_ready`  out  1  high in IDLE; the unit can accept a request.
- `store_addr`  in  ADDR_WIDTH  byte address of the first byte.
- `store_data`  in  32  store data. Bytes are taken from the low end per size.
- `store_size`  in  2  0=byte, 1=half, 2=word, 3=illegal.
- `store_done`  out  1  one-cycle pulse after the last byte is written.
- `store_misaligned`  out  1  one-cycle pulse when a request is rejected.
- `mem_addr`  out  ADDR_WIDTH  MMU port A address.
- `mem_data`  out  8  MMU port A write byte.
- `mem_we`  out  1  MMU write enable. High only together with `mem_request`.
- `mem_request`  out  1  MMU port A request.
- `mem_busy`  in  1  MMU port A busy.

## Operation

- States: IDLE, ISSUE, WAIT, DONE, ERR.
- IDLE: `store_ready`=1. When `store_valid`=1, latch addr, data and size, then:
  - legal request: byte count N = 1, 2 or 4; byte index k = 0; go to ISSUE.
  - illegal request: go to ERR.
- Byte k uses `mem_addr` = addr + k, modulo 2^ADDR_WIDTH (wraps to 0).
- Byte k data is big-endian:
  - word: bits [31:24], [23:16], [15:8], [7:0] for k = 0..3.
  - half: bits [15:8], then [7:0].
  - byte: bits [7:0].
- ISSUE: assert `mem_request` and `mem_we` with address and data for byte k. Next state WAIT.
- WAIT: hold `mem_request`, `mem_we`, `mem_addr` and `mem_data` stable.
  - `mem_busy`=1: stay in WAIT.
  - `mem_busy`=0: byte k is complete. If k < N-1, increment k and go to ISSUE; otherwise go to DONE.
- DONE: `store_done`=1 for one cycle, then IDLE.
- ERR: `store_misaligned`=1 for one cycle, no memory traffic, then IDLE.
- Illegal request: size 3 always; half with addr[0]=1; word with addr[1:0]≠0. The last two depend on configuration.
- `store_valid` outside IDLE is ignored. It is not queued.
- `reset` low at any edge, in any state:
  - next state is IDLE; the pending store is discarded.
  - `mem_request` and `mem_we` drop at that edge.
  - no `store_done` or `store_misaligned` pulse is produced.
- Reset values: `store_ready`=1, `mem_request`=0, `mem_we`=0, `mem_addr`=0, `mem_data`=0, `store_done`=0, `store_misaligned`=0.
- All outputs are registered or decoded from the state register. There is no combinational path from `mem_busy` to `mem_*`.

## Timing

- Accept edge is cycle 0. Timings below assume `mem_busy` stays 0.
- ISSUE for byte 0 is cycle 1; each byte takes 2 cycles (ISSUE + WAIT).
- `store_done` is high in cycle 2N+1: cycle 3 for byte, 5 for half, 9 for word.
- `store_ready` returns high in cycle 2N+2.
- Each busy cycle in WAIT adds exactly one cycle.
- `store_misaligned` is high in cycle 1; `store_ready` is high again in cycle 2.
- The MMU sees `mem_request` high for at least 2 consecutive cycles per byte. Between bytes it stays high, with address and data changing only at the ISSUE edge.

## Configuration

- `WORD_STORE_UNALIGNED_EN` defined:
  - half and word stores at any address are legal and written bytewise to addr..addr+N-1, with wrap-around.
  - only size 3 goes to ERR.
- Not defined: misaligned half/word requests are rejected through ERR as described above.

## Test plan

- sw, addr 0x100, data 0xDEADBEEF, busy=0 -> writes DE@0x100, AD@0x101, BE@0x102, EF@0x103; `store_done` in cycle 9; `store_ready` in cycle 10.
- sb, addr 0x7, data 0x123456AB -> single write AB@0x7; `store_done` in cycle 3; no other `mem_request`.
- sh, addr 0x2, data 0x0000CAFE, `mem_busy` held 1 for 3 cycles during byte 0 -> CA@0x2 held stable through the busy cycles, then FE@0x3; `store_done` in cycle 8.
- sw, addr 0x101, data 0x11223344:
  - macro off -> `store_misaligned` in cycle 1, no `mem_request`, `store_ready` in cycle 2.
  - macro on -> 11@0x101, 22@0x102, 33@0x103, 44@0x104.
- sw in progress, `reset` low during WAIT of byte 1 -> `mem_request`=0 at the next edge; no `store_done`; `store_ready`=1. A new sb afterwards completes normally.
- Macro on, sw at 0xFFFFFFFE, data 0xA1B2C3D4 -> A1@0xFFFFFFFE, B2@0xFFFFFFFF, C3@0x0, D4@0x1. `store_valid` pulsed mid-store -> ignored.
